// File: rtl/alu_share_pkg.sv
// Shared types and widths for the ALU-sharing sequencer and its arbiter.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OP_W  = 3;
  localparam int CNT_W = 16;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or above ptr, wrapping to 0.
module rr_arbiter
  import alu_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick;

  // Prefer requests at or above ptr; fall back to the full set to wrap, then isolate the lowest set bit.
  always_comb begin
    mask   = {NREQ{1'b1}} << ptr;
    masked = req & mask;
    pick   = (masked != '0) ? masked : req;
    gnt    = pick & (-pick);
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one add/sub ALU among NREQ requesters: round-robin accept, wait LAT cycles, return a one-cycle response.
// Optional per-requester grant counters are built when ALU_SHARE_STATS_EN is defined.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*W-1:0]      req_a,
  input  logic [NREQ*W-1:0]      req_b,
  input  logic [NREQ*OP_W-1:0]   req_op,
  output logic [2*W-1:0]         alu_ab,
  output logic [OP_W-1:0]        alu_op,
  input  logic [W-1:0]           alu_res,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [W-1:0]           rsp_data,
  output logic                   busy
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]  grant_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gsel;
  logic [PW-1:0]   gidx_nxt;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [OP_W-1:0] op_sel;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    gidx_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gidx_nxt = PW'(i);
    end
  end

  assign a_sel  = req_a[gidx_nxt*W +: W];
  assign b_sel  = req_b[gidx_nxt*W +: W];
  assign op_sel = req_op[gidx_nxt*OP_W +: OP_W];
  assign xfer   = |(req_valid & req_ready);

  // Grants are offered only from IDLE and never while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = rst ? gnt : '0;
        if (xfer) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == CW'(1)) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gsel      <= '0;
      cnt       <= '0;
      alu_ab    <= '0;
      alu_op    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (xfer) begin
            alu_ab <= {b_sel, a_sel};
            alu_op <= op_sel;
            gsel   <= gidx_nxt;
            cnt    <= CW'(LAT);
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_data  <= alu_res;
            rsp_valid <= NREQ'(1) << gsel;
          end
        end
        RESP: begin
          ptr <= (gsel == PW'(NREQ - 1)) ? '0 : gsel + PW'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ALU_SHARE_STATS_EN
  // Each requester's counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
    end else if (xfer && (grant_cnt[gidx_nxt*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
      grant_cnt[gidx_nxt*CNT_W +: CNT_W] <= grant_cnt[gidx_nxt*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: timestamp-based behavioural model plus directed literal checks.
module tb_alu_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   valid4 = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ*3-1:0] req_op = '0;

  logic [NREQ-1:0] req_ready, ready4;
  logic [2*W-1:0]  alu_ab, alu_ab4;
  logic [2:0]      alu_op, alu_op4;
  logic [W-1:0]    alu_res, alu_res4;
  logic [NREQ-1:0] rsp_valid, rsp_valid4;
  logic [W-1:0]    rsp_data, rsp_data4;
  logic            busy, busy4;
`ifdef ALU_SHARE_STATS_EN
  logic [NREQ*16-1:0] grant_cnt, grant_cnt4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [2*W-1:0] ab, input logic [2:0] op);
    logic [W-1:0] a, b;
    a = ab[W-1:0];
    b = ab[2*W-1:W];
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_res  = alu_f(alu_ab, alu_op);
  assign alu_res4 = alu_f(alu_ab4, alu_op4);

  alu_share_ctrl #(.NREQ(NREQ), .W(W), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_ab(alu_ab), .alu_op(alu_op), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
`ifdef ALU_SHARE_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  alu_share_ctrl #(.NREQ(NREQ), .W(W), .LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(valid4), .req_ready(ready4),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_ab(alu_ab4), .alu_op(alu_op4), .alu_res(alu_res4),
    .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .busy(busy4)
`ifdef ALU_SHARE_STATS_EN
    , .grant_cnt(grant_cnt4)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int slot, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op);
    req_a[slot*W +: W]  = a;
    req_b[slot*W +: W]  = b;
    req_op[slot*3 +: 3] = op;
  endtask

  // Behavioural model: each accepted op occupies the ALU for LAT+2 cycles and answers in the last of them.
  int             cyc = 0;
  int             m_ptr = 0;
  int             m_free_at = 0;
  int             m_resp_cyc = -1;
  int             m_resp_g = 0;
  logic [W-1:0]   m_resp_data = '0;
  logic [2*W-1:0] m_ab = '0;
  logic [2:0]     m_op = '0;
  int             m_cnt [NREQ];
  int             log_g [$];
  int             log_c [$];
  logic [W-1:0]   log_d [$];
  int             pulses4 = 0;

  always @(negedge clk) begin : model
    int g;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rsp;
    cyc++;
    if (rsp_valid4 != '0) pulses4++;
    if (!rst) begin
      checkOutput("rst_ready", req_ready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_alu_ab", alu_ab, 0);
      checkOutput("rst_alu_op", alu_op, 0);
      checkOutput("rst_rsp_data", rsp_data, 0);
      m_ptr = 0; m_free_at = 0; m_resp_cyc = -1; m_ab = '0; m_op = '0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else begin
      g = -1;
      if (cyc >= m_free_at) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_rsp = (cyc == m_resp_cyc) ? (NREQ'(1) << m_resp_g) : '0;
      checkOutput("model_ready", req_ready, exp_ready);
      checkOutput("model_rsp_valid", rsp_valid, exp_rsp);
      checkOutput("model_busy", busy, (cyc < m_free_at) ? 1 : 0);
      checkOutput("model_alu_ab", alu_ab, m_ab);
      checkOutput("model_alu_op", alu_op, m_op);
      if (cyc == m_resp_cyc) checkOutput("model_rsp_data", rsp_data, m_resp_data);
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          log_g.push_back(i);
          log_c.push_back(cyc);
          log_d.push_back(rsp_data);
        end
      end
      if (g >= 0) begin
        m_ab        = {req_b[g*W +: W], req_a[g*W +: W]};
        m_op        = req_op[g*3 +: 3];
        m_resp_g    = g;
        m_resp_cyc  = cyc + LAT + 1;
        m_resp_data = alu_f(m_ab, m_op);
        m_free_at   = cyc + LAT + 2;
        m_ptr       = (g + 1) % NREQ;
        if (m_cnt[g] < 65535) m_cnt[g]++;
      end
    end
  end

  initial begin
    #50000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset window
    #3 rst = 1'b0;
    #5;
    checkOutput("reset_ready", req_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_alu_ab", alu_ab, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    #5 rst = 1'b1;
    tick(1);

    // Single op from requester 2
    applyStimulus(2, 8'd3, 8'd4, 3'b000);
    req_valid = 4'b0100;
    #1 checkOutput("single_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    checkOutput("single_alu_ab", alu_ab, 16'h0403);
    checkOutput("single_busy", busy, 1);
    checkOutput("single_no_early_rsp", rsp_valid, 0);
    tick(1);
    checkOutput("single_rsp_valid", rsp_valid, 4'b0100);
    checkOutput("single_rsp_data", rsp_data, 8'd7);
    tick(1);
    checkOutput("single_rsp_one_cycle", rsp_valid, 0);
    checkOutput("single_idle", busy, 0);

    // Skip/wrap: ptr is 3, only requester 1 asks
    applyStimulus(1, 8'd5, 8'd2, 3'b001);
    req_valid = 4'b0010;
    #1 checkOutput("wrap_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    tick(1);
    checkOutput("wrap_rsp_valid", rsp_valid, 4'b0010);
    checkOutput("wrap_rsp_data", rsp_data, 8'd3);
    tick(1);
    req_valid = 4'b1111;
    #1 checkOutput("wrap_ptr_is_2", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    tick(3);

    // Single requester held valid: back-to-back service
    log_g.delete(); log_c.delete(); log_d.delete();
    applyStimulus(0, 8'd10, 8'd20, 3'b000);
    req_valid = 4'b0001;
    tick(12);
    req_valid = '0;
    tick(4);
    checkOutput("b2b_count", log_g.size(), 4);
    for (int i = 0; i < log_g.size(); i++) begin
      checkOutput("b2b_grant", log_g[i], 0);
      checkOutput("b2b_data", log_d[i], 8'd30);
      if (i > 0) checkOutput("b2b_spacing", log_c[i] - log_c[i-1], LAT + 2);
    end

    // Reset in the middle of a LAT=4 operation
    applyStimulus(1, 8'd1, 8'd1, 3'b000);
    valid4 = 4'b0010;
    tick(1);
    valid4 = '0;
    tick(2);
    checkOutput("mid_busy_before", busy4, 1);
    pulses4 = 0;
    rst = 1'b0;
    repeat (4) begin
      tick(1);
      checkOutput("mid_no_rsp", rsp_valid4, 0);
      checkOutput("mid_busy_reset", busy4, 0);
    end
    rst = 1'b1;
    tick(1);
    checkOutput("mid_pulses", pulses4, 0);
    checkOutput("mid_idle", busy4, 0);

    // Contention: all valid, subtract 9-3; LAT=4 instance also timed here
    log_g.delete(); log_c.delete(); log_d.delete();
    for (int s = 0; s < NREQ; s++) applyStimulus(s, 8'd9, 8'd3, 3'b001);
    req_valid = 4'b1111;
    valid4    = 4'b1111;
    #1;
    checkOutput("cont_ready_first", req_ready, 4'b0001);
    checkOutput("lat4_ready_first", ready4, 4'b0001);
    @(posedge clk); #1;
    valid4 = '0;
    tick(3);
    checkOutput("lat4_not_yet", rsp_valid4, 0);
    tick(1);
    checkOutput("lat4_rsp_valid", rsp_valid4, 4'b0001);
    checkOutput("lat4_rsp_data", rsp_data4, 8'd6);
    tick(10);
    req_valid = '0;
    tick(4);
    checkOutput("cont_count", log_g.size(), 5);
    for (int i = 0; i < log_g.size(); i++) begin
      checkOutput("cont_order", log_g[i], i % NREQ);
      checkOutput("cont_data", log_d[i], 8'd6);
      if (i > 0) checkOutput("cont_spacing", log_c[i] - log_c[i-1], LAT + 2);
    end

`ifdef ALU_SHARE_STATS_EN
    for (int i = 0; i < NREQ; i++) checkOutput("stats_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
